// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the req/addr_ok/data_ok
// instruction SRAM port, applies static branch prediction, feeds decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_allowin,
  input  logic        flush,
  input  logic [31:0] pc_real,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        IF_to_ID_valid,
  output logic [64:0] IF_to_ID_zip
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_IDLE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_run;
  logic        r_drop;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [64:0] r_zip;

  logic        w_slot_free;
  logic        w_acc;
  logic        w_take;
  logic        w_pred;
  logic [5:0]  w_op;
  logic [31:0] w_off26;
  logic [31:0] w_off16;
  logic [31:0] w_next;

  // A request may only go out when the slot is empty or draining this cycle,
  // so returning data always finds a free slot.
  assign w_slot_free    = ~r_valid | ID_allowin;
  assign inst_sram_req  = r_run & (r_state != S_WAIT) & w_slot_free;
  assign inst_sram_addr = {r_pc[31:2], 2'b00};
  assign w_acc          = inst_sram_req & inst_sram_addr_ok;
  assign w_take         = (r_state == S_WAIT) & inst_sram_data_ok & ~r_drop & ~flush;

  assign w_op    = inst_sram_rdata[31:26];
  assign w_off26 = {{4{inst_sram_rdata[9]}}, inst_sram_rdata[9:0],
                    inst_sram_rdata[25:10], 2'b00};
  assign w_off16 = {{14{inst_sram_rdata[25]}}, inst_sram_rdata[25:10], 2'b00};

  // b/bl always taken; conditional branches taken only when pointing backward
  always_comb begin
    w_pred = 1'b0;
    w_next = r_pc + 32'd4;
    if (w_op == 6'h14 || w_op == 6'h15) begin
      w_pred = 1'b1;
      w_next = r_pc + w_off26;
    end else if (w_op >= 6'h16 && w_op <= 6'h1B) begin
      w_pred = inst_sram_rdata[25];
      if (inst_sram_rdata[25]) w_next = r_pc + w_off16;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
      r_run   <= 1'b0;
      r_drop  <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      r_run <= 1'b1;
      if (flush) begin
        r_pc <= pc_real;
        if (r_state == S_WAIT) begin
          if (inst_sram_data_ok) begin
            r_state <= S_REQ;
            r_drop  <= 1'b0;
          end else begin
            r_drop  <= 1'b1;
          end
        end else if (w_acc) begin
          r_state <= S_WAIT;
          r_drop  <= 1'b1;
        end else begin
          r_state <= S_REQ;
          r_drop  <= 1'b0;
        end
      end else begin
        case (r_state)
          S_REQ: if (w_acc) r_state <= S_WAIT;
          S_WAIT: begin
            if (inst_sram_data_ok) begin
              r_drop <= 1'b0;
              if (r_drop) begin
                r_state <= S_REQ;
              end else begin
                r_pc    <= w_next;
                r_state <= ID_allowin ? S_REQ : S_IDLE;
              end
            end
          end
          S_IDLE: begin
            if (w_acc)           r_state <= S_WAIT;
            else if (ID_allowin) r_state <= S_REQ;
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_zip   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_zip   <= {w_pred, inst_sram_rdata, r_pc};
    end else if (ID_allowin) begin
      r_valid <= 1'b0;
    end
  end

  assign IF_to_ID_valid = r_valid;
  assign IF_to_ID_zip   = r_zip;

endmodule
